// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, data width
// and default watchdog / inter-frame gap lengths.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int DEF_TIMEOUT_TICKS = 16;
    localparam int DEF_GAP_TICKS     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly above 'last',
// wrapping to the lowest set bit when nothing above it is requesting.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_v;

    // Descending scan so the final assignment holds the lowest qualifying index.
    always_comb begin
        hi_v   = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                if (i > int'(last)) begin
                    hi_v   = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
        winner = hi_v ? hi_idx : lo_idx;
        valid  = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N requesters, with a
// baud-tick watchdog. Define UART_ARB_GAP_EN to enforce an idle gap between frames.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N             = 4,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int GAP_TICKS     = DEF_GAP_TICKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     baud_tick,
    input  logic [N-1:0]             req,
    input  logic [N*UART_DATA_W-1:0] req_data,
    output logic [N-1:0]             ack,
    output logic                     tx_start,
    output logic [UART_DATA_W-1:0]   tx_data,
    input  logic                     tx_done,
    output logic [$clog2(N)-1:0]     grant_id,
    output logic                     busy,
    output logic                     timeout_err,
    output arb_state_e               dbg_state
);

    // Handshake: req[i] is a level held until ack[i]; ack[i] is a one-cycle pulse
    // in the same cycle as tx_start, when tx_data already holds byte i.
    localparam int IW = $clog2(N);
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_TICKS);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("uart_tx_arbiter: N must be 2..8");
    end
    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_TICKS must be 1..255");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 15) begin : g_bad_gap
        $error("uart_tx_arbiter: GAP_TICKS must be 1..15");
    end

    arb_state_e             state_q, state_d;
    logic [N-1:0]           ack_q, ack_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic [7:0]             wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;
`ifdef UART_ARB_GAP_EN
    localparam logic [3:0] GAP_LIMIT = 4'(GAP_TICKS);
    logic [3:0]             gap_q, gap_d;
`endif

    logic [IW-1:0]          pick_id;
    logic                   pick_valid;
    logic [UART_DATA_W-1:0] pick_data;
    logic [N-1:0]           pick_onehot;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_data   = '0;
        pick_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_id == IW'(i)) begin
                pick_data      = req_data[i*UART_DATA_W +: UART_DATA_W];
                pick_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        timeout_d  = 1'b0;
`ifdef UART_ARB_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    ack_d      = pick_onehot;
                    tx_start_d = 1'b1;
                    tx_data_d  = pick_data;
                    grant_d    = pick_id;
                    last_d     = pick_id;
                    wdog_d     = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A done coincident with the launch belongs to no frame of ours.
                if (!tx_start_q && tx_done) begin
`ifdef UART_ARB_GAP_EN
                    gap_d   = '0;
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end else if (baud_tick) begin
                    if (wdog_q >= WDOG_LIMIT - 8'd1) begin
                        wdog_d    = WDOG_LIMIT;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end
            end
`ifdef UART_ARB_GAP_EN
            GAP: begin
                if (baud_tick) begin
                    if (gap_q >= GAP_LIMIT - 4'd1) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            last_q     <= IW'(N - 1);
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
`ifdef UART_ARB_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
`ifdef UART_ARB_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a round-robin reference model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int GT = 2;
`ifdef UART_ARB_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif
  localparam logic [31:0] DATA = 32'hC3_00_3C_A5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         baud_tick = 1'b0;
  logic [N-1:0] req = '0;
  logic [31:0]  req_data = DATA;
  logic         tx_done = 1'b0;
  logic [N-1:0] ack;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;
  arb_state_e   dbg_state;

  uart_tx_arbiter #(.N(N), .TIMEOUT_TICKS(TO), .GAP_TICKS(GT)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- environment state ----------------
  bit auto_tx = 0;
  bit auto_baud = 0;
  bit auto_req = 0;
  bit rand_frames = 0;
  bit model_on = 0;
  bit tx_busy = 0;
  int tx_remain = 0;

  // reference model: round-robin pointer plus a coarse phase of the shared line
  int m_last = N - 1;
  int m_phase = 0;      // 0 free, 1 frame in flight, 2 enforced gap
  int m_wd = 0;
  int m_gap = 0;
  bit m_first = 0;
  logic [9:0] exp_q[$]; // {grant, byte}

  function automatic int rr_next(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input bit s_rst, input logic [N-1:0] s_req, input logic [31:0] s_data,
                            input bit s_tick, input bit s_done);
    bit exp_start;
    bit exp_to;
    logic [9:0] e;
    int w;
    exp_start = 0;
    exp_to = 0;
    if (s_rst) begin
      m_phase = 0;
      m_last = N - 1;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (s_req != 0) begin
          w = rr_next(m_last, s_req);
          m_last = w;
          exp_start = 1;
          m_phase = 1;
          m_wd = 0;
          m_first = 1;
          exp_q.push_back({2'(w), s_data[w*8 +: 8]});
        end
        1: begin
          if (!m_first && s_done) begin
            m_phase = GAP_ON ? 2 : 0;
            m_gap = 0;
          end else if (s_tick) begin
            m_wd++;
            if (m_wd == TO) begin
              exp_to = 1;
              m_phase = 0;
            end
          end
          m_first = 0;
        end
        default: if (s_tick) begin
          m_gap++;
          if (m_gap == GT) m_phase = 0;
        end
      endcase
    end
    check("rand_tx_start", tx_start, exp_start);
    check("rand_timeout", timeout_err, exp_to);
    check("rand_busy", busy, m_phase != 0);
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        check("rand_unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rand_grant", grant_id, e[9:8]);
        check("rand_data", tx_data, e[7:0]);
        check("rand_ack", ack, 4'b0001 << e[9:8]);
      end
    end else begin
      check("rand_ack_idle", ack, 0);
    end
  endtask

  // One clock: sample after the edge, run the model, then drive the next inputs.
  task automatic tick();
    logic [N-1:0] s_req;
    logic [31:0] s_data;
    bit s_tick, s_done, s_rst;
    @(posedge clk);
    #1;
    s_req = req;
    s_data = req_data;
    s_tick = baud_tick;
    s_done = tx_done;
    s_rst = reset;
    if (model_on) model_step(s_rst, s_req, s_data, s_tick, s_done);
    if (auto_tx) begin
      tx_done = 1'b0;
      if (timeout_err || s_rst) tx_busy = 0;
      else if (tx_busy && s_tick) begin
        tx_remain--;
        if (tx_remain == 0) begin
          tx_done = 1'b1;
          tx_busy = 0;
        end
      end
      if (tx_start && !s_rst) begin
        tx_busy = 1;
        tx_remain = rand_frames ? $urandom_range(1, 24) : 10;
      end
    end
    if (auto_baud) baud_tick = ($urandom_range(0, 2) == 0);
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 3) == 0) req_data[i*8 +: 8] = 8'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    baud_tick = 1'b0;
    tx_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Finish an outstanding frame and any gap with no requests pending.
  task automatic drain();
    req = '0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    baud_tick = 1'b1;
    tick();
    tick();
    baud_tick = 1'b0;
    tick();
    check("drain_idle", busy, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         baud;
    bit         done;
    logic [3:0] e_ack;
    bit         e_st;
    logic [7:0] e_data;
    logic [1:0] e_grant;
    bit         e_busy;
    bit         e_to;
  } vec_t;

  vec_t vec[27];

  initial begin
    int n_st, n_ack, cyc;
    vec[0]  = '{1, 4'h0, 0, 0, 4'h0, 0, 8'h00, 2'd0, 0, 0};
    vec[1]  = '{0, 4'h1, 0, 0, 4'h1, 1, 8'hA5, 2'd0, 1, 0};
    vec[2]  = '{0, 4'h0, 0, 1, 4'h0, 0, 8'hA5, 2'd0, 1, 0};
    vec[3]  = '{0, 4'h0, 0, 0, 4'h0, 0, 8'hA5, 2'd0, 1, 0};
    vec[4]  = '{0, 4'h0, 0, 1, 4'h0, 0, 8'hA5, 2'd0, GAP_ON, 0};
    vec[5]  = '{0, 4'h0, 1, 0, 4'h0, 0, 8'hA5, 2'd0, GAP_ON, 0};
    vec[6]  = '{0, 4'h0, 1, 0, 4'h0, 0, 8'hA5, 2'd0, 0, 0};
    vec[7]  = '{0, 4'h2, 0, 0, 4'h2, 1, 8'h3C, 2'd1, 1, 0};
    vec[8]  = '{0, 4'h0, 0, 0, 4'h0, 0, 8'h3C, 2'd1, 1, 0};
    vec[9]  = '{0, 4'h0, 0, 1, 4'h0, 0, 8'h3C, 2'd1, GAP_ON, 0};
    vec[10] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'h3C, 2'd1, GAP_ON, 0};
    vec[11] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'h3C, 2'd1, 0, 0};
    vec[12] = '{0, 4'hA, 0, 0, 4'h8, 1, 8'hC3, 2'd3, 1, 0};
    vec[13] = '{0, 4'h2, 0, 0, 4'h0, 0, 8'hC3, 2'd3, 1, 0};
    vec[14] = '{0, 4'h0, 0, 1, 4'h0, 0, 8'hC3, 2'd3, GAP_ON, 0};
    vec[15] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'hC3, 2'd3, GAP_ON, 0};
    vec[16] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'hC3, 2'd3, 0, 0};
    vec[17] = '{0, 4'hA, 0, 0, 4'h2, 1, 8'h3C, 2'd1, 1, 0};
    vec[18] = '{0, 4'h8, 0, 0, 4'h0, 0, 8'h3C, 2'd1, 1, 0};
    vec[19] = '{0, 4'h0, 0, 1, 4'h0, 0, 8'h3C, 2'd1, GAP_ON, 0};
    vec[20] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'h3C, 2'd1, GAP_ON, 0};
    vec[21] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'h3C, 2'd1, 0, 0};
    vec[22] = '{0, 4'hA, 0, 0, 4'h8, 1, 8'hC3, 2'd3, 1, 0};
    vec[23] = '{0, 4'h0, 0, 1, 4'h0, 0, 8'hC3, 2'd3, 1, 0};
    vec[24] = '{0, 4'h0, 0, 1, 4'h0, 0, 8'hC3, 2'd3, GAP_ON, 0};
    vec[25] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'hC3, 2'd3, GAP_ON, 0};
    vec[26] = '{0, 4'h0, 1, 0, 4'h0, 0, 8'hC3, 2'd3, 0, 0};

    for (int k = 0; k < 27; k++) begin
      reset = vec[k].rst;
      req = vec[k].req;
      req_data = DATA;
      baud_tick = vec[k].baud;
      tx_done = vec[k].done;
      tick();
      check($sformatf("vec%0d_ack", k), ack, vec[k].e_ack);
      check($sformatf("vec%0d_start", k), tx_start, vec[k].e_st);
      check($sformatf("vec%0d_data", k), tx_data, vec[k].e_data);
      check($sformatf("vec%0d_grant", k), grant_id, vec[k].e_grant);
      check($sformatf("vec%0d_busy", k), busy, vec[k].e_busy);
      check($sformatf("vec%0d_timeout", k), timeout_err, vec[k].e_to);
    end
    tx_done = 1'b0;
    baud_tick = 1'b0;

    // ---------- watchdog expiry with a silent transmitter ----------
    do_reset();
    req = 4'b0001;
    tick();
    check("to_start", tx_start, 1);
    req = '0;
    for (int t = 1; t <= TO; t++) begin
      baud_tick = 1'b1;
      tick();
      check($sformatf("to_tick%0d_err", t), timeout_err, t == TO);
      check($sformatf("to_tick%0d_busy", t), busy, t != TO);
      baud_tick = 1'b0;
      tick();
      check($sformatf("to_gap%0d_err", t), timeout_err, 0);
    end
    req = 4'b0100;
    tick();
    check("after_to_start", tx_start, 1);
    check("after_to_grant", grant_id, 2);
    check("after_to_ack", ack, 4'b0100);
    drain();

    // ---------- done coincident with the final watchdog tick ----------
    req = 4'b0001;
    tick();
    check("coin_grant", grant_id, 0);
    req = '0;
    tx_done = 1'b1;
    tick();
    check("done_in_start_cycle_busy", busy, 1);
    tx_done = 1'b0;
    for (int t = 1; t < TO; t++) begin
      baud_tick = 1'b1;
      tick();
      check($sformatf("coin_tick%0d_err", t), timeout_err, 0);
    end
    tx_done = 1'b1;
    tick();
    check("coin_err", timeout_err, 0);
    check("coin_busy", busy, GAP_ON);
    tx_done = 1'b0;
    baud_tick = 1'b0;
    tick();
    check("coin_err_after", timeout_err, 0);
    check("coin_busy_after", busy, GAP_ON);
    baud_tick = 1'b1;
    tick();
    tick();
    baud_tick = 1'b0;
    tick();
    check("coin_idle", busy, 0);

    // ---------- reset in the middle of a frame ----------
    req = 4'b0100;
    tick();
    check("mid_rst_grant", grant_id, 2);
    req = '0;
    tick();
    reset = 1'b1;
    req = 4'b1111;
    tick();
    check("mid_rst_ack", ack, 0);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_grant0", grant_id, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", timeout_err, 0);
    reset = 1'b0;
    tick();
    check("post_rst_grant", grant_id, 0);
    check("post_rst_ack", ack, 4'b0001);
    check("post_rst_start", tx_start, 1);
    drain();

    // ---------- rotation with all requesters holding ----------
    do_reset();
    auto_tx = 1;
    auto_baud = 1;
    rand_frames = 0;
    req = 4'b1111;
    n_st = 0;
    n_ack = 0;
    cyc = 0;
    while (n_st < 5 && cyc < 3000) begin
      tick();
      cyc++;
      if (ack != 0) n_ack++;
      if (tx_start) begin
        check($sformatf("rot%0d_grant", n_st), grant_id, n_st % N);
        check($sformatf("rot%0d_ack", n_st), ack, 4'b0001 << (n_st % N));
        n_st++;
      end
    end
    check("rot_frames", n_st, 5);
    check("rot_acks", n_ack, 5);
    req = '0;
    cyc = 0;
    while (busy && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("rot_drained", busy, 0);

    // ---------- randomized run against the reference model ----------
    rand_frames = 1;
    model_on = 1;
    do_reset();
    auto_req = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    check("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
